pipelined_carry_adder: RTL
==========================

// Module: pipelined_carry_adder
// PURPOSE
//  Parametrised, pipelined successor to the 4-bit ripple-carry adder: WIDTH-bit add/subtract
//  with carry-in, split into STAGES carry-registered slices for timing closure.
//  Valid/ready streaming interface with full back-pressure; one result per cycle sustained.
//  Sits in datapaths (accumulators, address generators) needing wide adds at high clock rate.
// PARAMETERS
//  WIDTH   16  operand/sum width in bits; must be a multiple of STAGES
//  STAGES  4   pipeline depth = number of slices; slice width SW = WIDTH/STAGES (>=1)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      block can accept a beat this cycle
//  a          in   WIDTH  operand A (unsigned / two's complement)
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in (ignored when sub=1)
//  sub        in   1      0: a+b+cin; 1: a-b (a + ~b + 1)
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts result
//  sum        out  WIDTH  result modulo 2^WIDTH
//  cout       out  1      carry-out (sub=1: 1 = no borrow, a>=b unsigned)
//  ovf        out  1      signed overflow; present only with PCA_OVF_EN
// BEHAVIOUR
//  - Reset (async assert, sync-safe release): all stage valid bits, sum, cout, ovf = 0;
//    in-flight beats discarded; in_ready = 1 in the first cycle after release.
//  - Global stall: adv = !out_valid | out_ready; in_ready = adv (combinational).
//    Beat accepted when in_valid & in_ready. When adv=0 every stage holds (data+valid).
//  - Stage k (0..STAGES-1) adds slice k of a and b_eff plus carry from stage k-1
//    (stage 0 uses cin_eff); registers its SW-bit partial sum and carry-out.
//    Upper operand slices are skewed through shift registers so slice k meets its carry.
//    Already-computed lower sum slices are delayed so all slices emerge aligned.
//  - b_eff = sub ? ~b : b; cin_eff = sub ? 1 : cin; sub/cin captured with the beat.
//  - Latency: exactly STAGES cycles from accept to out_valid with no stall;
//    throughput 1 beat/cycle with out_ready held high; bubbles (in_valid=0) propagate
//    as invalid slots, never as repeated results.
//  - Outputs change only when adv=1; while out_valid & !out_ready, sum/cout/ovf stable.
//  - Wrap-around: sum = (a + b_eff + cin_eff) mod 2^WIDTH, cout = bit WIDTH of full sum.
//  - STAGES=1: single registered adder, latency 1, same handshake.
//  - Simultaneous accept and output-drain in the same cycle: both occur, no beat lost.
// CONFIGURATION
//  - PCA_OVF_EN defined: ovf port exists; ovf = carry into MSB XOR cout (signed overflow),
//    registered and aligned with sum; reset 0.
//  - PCA_OVF_EN undefined: ovf port and its logic absent; all other behaviour identical.
// STRUCTURE
//  - Shared package adder_pkg: slice-width function/constant derivation (SW), stage-index
//    width, legality check WIDTH % STAGES == 0 (elaboration error otherwise).
//  - Sub-module pca_slice_stage: one SW-bit add of slice + carry-in, registered sum slice
//    and carry-out with hold enable (adv); instantiated STAGES times by generate loop.
//  - Top holds skew/deskew shift registers, valid chain, handshake logic.
// TESTING (WIDTH=16, STAGES=4 unless noted)
//  - a=FFFF b=0001 cin=0 sub=0 -> sum=0000 cout=1 exactly 4 cycles after accept.
//  - sub=1 a=0005 b=0007 -> sum=FFFE cout=0; a=0007 b=0005 -> sum=0002 cout=1.
//  - PCA_OVF_EN: a=7FFF b=0001 -> ovf=1; a=8000 b=FFFF -> sum=7FFF cout=1 ovf=1; 0001+0001 -> ovf=0.
//  - 100 random back-to-back beats, out_ready=1 -> 100 results in order, one per cycle,
//    each matching reference model (a+b_eff+cin_eff).
//  - out_ready=0 for 6 cycles mid-stream -> in_ready=0 once out_valid, sum held stable,
//    no loss/duplication after release.
//  - rst asserted with 3 beats in flight -> out_valid=0, sum=0 immediately; no stale beat
//    emerges after release; STAGES=1 and STAGES=16 (SW=1) rerun of first scenario.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared helpers for the pipelined carry adder: slice sizing and legality.
package adder_pkg;

    function automatic int slice_w(input int w, input int s);
        return w / s;
    endfunction

    function automatic int idx_w(input int s);
        return (s > 1) ? $clog2(s) : 1;
    endfunction

    function automatic bit cfg_ok(input int w, input int s);
        return (s >= 1) && (w >= s) && ((w % s) == 0);
    endfunction

endpackage

// File: rtl/pca_slice_stage.sv
// One SW-bit carry slice: adds operand slices plus carry-in and
// registers the partial sum and carry-out, holding while adv is low.
module pca_slice_stage #(
    parameter int SW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          adv,
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          ci,
    output logic [SW-1:0] s,
    output logic          co
);

    logic [SW:0] t;

    assign t = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, ci};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s  <= '0;
            co <= 1'b0;
        end else if (adv) begin
            s  <= t[SW-1:0];
            co <= t[SW];
        end
    end

endmodule

// File: rtl/pipelined_carry_adder.sv
// WIDTH-bit add/sub split into STAGES registered carry slices, valid/ready.
// Define PCA_OVF_EN to add the registered signed-overflow output ovf.
module pipelined_carry_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef PCA_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int SW = slice_w(WIDTH, STAGES);

    if (!cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
        $error("pipelined_carry_adder: WIDTH must be a multiple of STAGES");
    end

    logic              adv;
    logic [STAGES-1:0] vld;
    logic [WIDTH-1:0]  beff;
    logic              ceff;

    // [k][j]: slice j as held in the stage-k register bank
    logic [SW-1:0] pa [STAGES][STAGES];
    logic [SW-1:0] pb [STAGES][STAGES];
    logic [SW-1:0] ps [STAGES][STAGES];

    logic [SW-1:0] ia [STAGES];
    logic [SW-1:0] ib [STAGES];
    logic          ic [STAGES];
    logic          cy [STAGES];

    assign adv       = !vld[STAGES-1] | out_ready;
    assign in_ready  = adv;
    assign out_valid = vld[STAGES-1];
    assign beff      = sub ? ~b : b;
    assign ceff      = sub | cin;
    assign cout      = cy[STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
        end else if (adv) begin
            vld[0] <= in_valid;
            for (int k = 1; k < STAGES; k++) begin
                vld[k] <= vld[k-1];
            end
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign ia[0] = a[SW-1:0];
            assign ib[0] = beff[SW-1:0];
            assign ic[0] = ceff;
        end else begin : g_next
            assign ia[k] = pa[k-1][k];
            assign ib[k] = pb[k-1][k];
            assign ic[k] = cy[k-1];
        end

        pca_slice_stage #(.SW(SW)) u_slice (
            .clk (clk),
            .rst (rst),
            .adv (adv),
            .a   (ia[k]),
            .b   (ib[k]),
            .ci  (ic[k]),
            .s   (ps[k][k]),
            .co  (cy[k])
        );

        for (genvar j = 0; j < STAGES; j++) begin : g_col
            if (j > k) begin : g_skew
                // upper operand slices wait here for their carry
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        pa[k][j] <= '0;
                        pb[k][j] <= '0;
                    end else if (adv) begin
                        if (k == 0) begin
                            pa[k][j] <= a[j*SW +: SW];
                            pb[k][j] <= beff[j*SW +: SW];
                        end else begin
                            pa[k][j] <= pa[(k > 0) ? k-1 : 0][j];
                            pb[k][j] <= pb[(k > 0) ? k-1 : 0][j];
                        end
                    end
                end
            end else if (j < k) begin : g_deskew
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        ps[k][j] <= '0;
                    end else if (adv) begin
                        ps[k][j] <= ps[k-1][j];
                    end
                end
            end
        end
    end

    always_comb begin
        sum = '0;
        for (int j = 0; j < STAGES; j++) begin
            sum[j*SW +: SW] = ps[STAGES-1][j];
        end
    end

`ifdef PCA_OVF_EN
    logic am;
    logic bm;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            am <= 1'b0;
            bm <= 1'b0;
        end else if (adv) begin
            am <= ia[STAGES-1][SW-1];
            bm <= ib[STAGES-1][SW-1];
        end
    end

    // carry into the MSB is a^b^sum there; overflow when it differs from cout
    assign ovf = am ^ bm ^ sum[WIDTH-1] ^ cout;
`endif

endmodule
